// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - bus bundle between instruction fetch, ROM, redirect source and decoder
//
// Purpose: groups the ROM port, the redirect request and the IF/ID slot handshake.
// master modport = fetch stage, slave modport = surrounding pipeline/ROM.
//   instr_addr     fetch -> ROM      byte address (current pc)
//   instr_data     ROM -> fetch      word at instr_addr, same cycle
//   redirect_valid pipe -> fetch     take redirect_pc this cycle
//   redirect_pc    pipe -> fetch     redirect target byte address
//   out_valid      fetch -> decoder  slot holds an instruction
//   out_ready      decoder -> fetch  decoder accepts the slot
//   out_instr      fetch -> decoder  slot instruction
//   out_pc         fetch -> decoder  address of out_instr
//   out_pc_plus4   fetch -> decoder  out_pc + 4
//   fetch_err      fetch -> pipe     sticky misaligned-redirect flag
interface instr_fetch_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_err;

  modport master (
    output instr_addr,
    input  instr_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output fetch_err
  );

  modport slave (
    input  instr_addr,
    output instr_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  fetch_err
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: program counter, ROM addressing and registered IF/ID slot
//
// Purpose: walks the pc through a combinational instruction ROM and captures each word into a
// single valid/ready slot for the decoder; accepts branch/jump redirects.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous reset, active-low
//   bus    instr_fetch_if.master (ROM address/data, redirect, IF/ID slot, fetch_err)
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_DEPTH * 4);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        fetch_err_q;

  logic        in_range;
  logic        load;
  logic [31:0] pc_d;

  assign in_range = (pc_q < ROM_LIMIT);
  // A new word may enter the slot when it is empty or being drained this same cycle.
  assign load     = (state_q == ST_RUN) && in_range && (!out_valid_q || bus.out_ready);
  assign pc_d     = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'd0;
      fetch_err_q <= 1'b0;
    end else if (state_q == ST_ERR) begin
      // Stuck until reset: no fetches, redirects ignored, slot already emptied on entry.
      state_q <= ST_ERR;
    end else if (bus.redirect_valid) begin
      // The slot belongs to the wrong path, so it is discarded even if the decoder is ready.
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_q    <= bus.redirect_pc;
        state_q <= ST_RUN;
      end else begin
        state_q     <= ST_ERR;
        fetch_err_q <= 1'b1;
      end
    end else begin
      if ((state_q == ST_RUN) && !in_range) begin
        state_q <= ST_HALT;
      end
      if (load) begin
        out_instr_q <= bus.instr_data;
        out_pc_q    <= pc_q;
        out_valid_q <= 1'b1;
        pc_q        <= pc_d;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_instr_q <= NOP_INSTR;
      end
    end
  end

  assign bus.instr_addr   = pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_pc_plus4 = out_pc_q + 32'd4;
  assign bus.fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  logic [31:0] rom [16];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_DEPTH(16),
    .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.instr_data = (bus.instr_addr < 32'd64) ? rom[bus.instr_addr[5:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic        chk_pc;
    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_t;

  vec_t tbl [13];
  sb_t  sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] pc);
    sb_t e;
    e.pc    = pc;
    e.instr = rom[pc[5:2]];
    e.pc4   = pc + 32'd4;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; a slot accepted at the coming edge is popped and compared.
  task automatic step(input logic rst_n, input logic rv, input logic [31:0] rpc, input logic rdy);
    sb_t e;
    reset              = rst_n;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    if (rst_n && !rv && rdy && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: accepted out_pc %h with empty scoreboard", bus.out_pc);
      end else begin
        e = sb.pop_front();
        check32("sb_pc", bus.out_pc, e.pc);
        check32("sb_instr", bus.out_instr, e.instr);
        check32("sb_pc4", bus.out_pc_plus4, e.pc4);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [31:0] eaddr,
                             input logic eerr);
    check32({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
    check32({tag, "_addr"}, bus.instr_addr, eaddr);
    check32({tag, "_err"}, 32'(bus.fetch_err), 32'(eerr));
    if (!ev) check32({tag, "_nop"}, bus.out_instr, NOP);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 32'h0AB0_0000 + 32'(k * 32'h111);

    // Sequential fetch, backpressure, redirect during stall, reset mid-stream.
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h04};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h08};
    tbl[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0C};
    tbl[3]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0C};
    tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0C};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0C};
    tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h10};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h14};
    tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h14};
    tbl[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h18};
    tbl[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h04};

    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check_state("reset", 1'b0, 32'h0, 1'b0);
    check32("reset_out_pc", bus.out_pc, 32'h0);
    check32("reset_pc4", bus.out_pc_plus4, 32'h4);

    sb_push(32'h00);
    sb_push(32'h04);
    sb_push(32'h08);
    sb_push(32'h0C);
    sb_push(32'h10);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst_n, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check_state($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_addr, tbl[i].exp_err);
      if (tbl[i].chk_pc) check32($sformatf("vec%0d_out_pc", i), bus.out_pc, tbl[i].exp_pc);
      if (tbl[i].exp_valid)
        check32($sformatf("vec%0d_instr", i), bus.out_instr, rom[tbl[i].exp_pc[5:2]]);
    end

    // Misaligned redirect: sticky error, aligned redirect ignored, reset clears.
    step(1'b1, 1'b1, 32'h0A, 1'b1);
    check_state("mis0", 1'b0, 32'h04, 1'b1);
    step(1'b1, 1'b0, 32'h00, 1'b1);
    check_state("mis1", 1'b0, 32'h04, 1'b1);
    step(1'b1, 1'b0, 32'h00, 1'b1);
    check_state("mis2", 1'b0, 32'h04, 1'b1);
    step(1'b1, 1'b1, 32'h20, 1'b1);
    check_state("mis_ign", 1'b0, 32'h04, 1'b1);
    step(1'b0, 1'b0, 32'h00, 1'b1);
    check_state("mis_rst", 1'b0, 32'h00, 1'b0);

    // Run to the ROM end, drain, halt, then restart via redirect.
    for (int k = 0; k < 16; k++) sb_push(32'(k * 4));
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 32'h00, 1'b1);
      check32($sformatf("run%0d_pc", k), bus.out_pc, 32'(k * 4));
      check32($sformatf("run%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    step(1'b1, 1'b0, 32'h00, 1'b1);
    check_state("halt0", 1'b0, 32'h40, 1'b0);
    step(1'b1, 1'b0, 32'h00, 1'b1);
    check_state("halt1", 1'b0, 32'h40, 1'b0);
    step(1'b1, 1'b1, 32'h00, 1'b1);
    check_state("restart", 1'b0, 32'h00, 1'b0);
    sb_push(32'h00);
    step(1'b1, 1'b0, 32'h00, 1'b0);
    check_state("restart_ld", 1'b1, 32'h04, 1'b0);
    check32("restart_pc", bus.out_pc, 32'h00);
    step(1'b1, 1'b0, 32'h00, 1'b1);
    check32("after_restart_pc", bus.out_pc, 32'h04);
    step(1'b1, 1'b0, 32'h00, 1'b0);

    check32("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
